// File: rtl/rrf_multi_commit.sv
// Retirement register file: committed arch->phys map, multi-port in-order commit,
// freed-tag return and multi-beat restore stream. Optional check: RRF_DUP_TAG_CHECK_EN.
module rrf_multi_commit #(
    parameter int unsigned ARCH_REGS     = 32,
    parameter int unsigned PTAG_W        = 6,
    parameter int unsigned COMMIT_WIDTH  = 2,
    parameter int unsigned RESTORE_LANES = 8,
    localparam int unsigned AREG_W       = $clog2(ARCH_REGS)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [COMMIT_WIDTH-1:0]           commit_valid,
    input  logic [COMMIT_WIDTH*AREG_W-1:0]    commit_rd,
    input  logic [COMMIT_WIDTH*PTAG_W-1:0]    commit_ptag,
    output logic                              commit_ready,
    output logic [COMMIT_WIDTH-1:0]           free_valid,
    output logic [COMMIT_WIDTH*PTAG_W-1:0]    free_ptag,
    input  logic                              recover_req,
    output logic                              restore_valid,
    output logic [AREG_W-1:0]                 restore_base,
    output logic [RESTORE_LANES*PTAG_W-1:0]   restore_ptag,
    output logic                              restore_done,
    output logic [ARCH_REGS*PTAG_W-1:0]       rrf_map,
    output logic                              dup_err
);

    localparam int unsigned N_BEATS = ARCH_REGS / RESTORE_LANES;
    localparam int unsigned BEAT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

    typedef enum logic {S_IDLE, S_RESTORE} state_e;

    state_e                      state_q, state_d;
    logic [BEAT_W-1:0]           beat_q, beat_d;
    logic                        ready_q;
    logic [PTAG_W-1:0]           map_q [ARCH_REGS];
    logic [PTAG_W-1:0]           map_d [ARCH_REGS];
    logic [COMMIT_WIDTH-1:0]         free_valid_q, free_valid_d;
    logic [COMMIT_WIDTH*PTAG_W-1:0]  free_ptag_q, free_ptag_d;
    logic [COMMIT_WIDTH-1:0]     acc_c;
    logic [AREG_W-1:0]           rd_c   [COMMIT_WIDTH];
    logic [PTAG_W-1:0]           ptag_c [COMMIT_WIDTH];
    logic                        last_beat_c;

    always_comb begin
        acc_c = commit_valid & {COMMIT_WIDTH{ready_q}};
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            rd_c[k]   = commit_rd[k*AREG_W +: AREG_W];
            ptag_c[k] = commit_ptag[k*PTAG_W +: PTAG_W];
        end
    end

    // Map update (youngest port wins) and freed-tag selection with intra-cycle bypass.
    always_comb begin
        map_d        = map_q;
        free_valid_d = '0;
        free_ptag_d  = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (acc_c[k] && rd_c[k] != '0) begin
                map_d[rd_c[k]] = ptag_c[k];
                free_valid_d[k] = 1'b1;
                free_ptag_d[k*PTAG_W +: PTAG_W] = map_q[rd_c[k]];
                for (int i = 0; i < k; i++) begin
                    if (acc_c[i] && rd_c[i] == rd_c[k]) begin
                        free_ptag_d[k*PTAG_W +: PTAG_W] = ptag_c[i];
                    end
                end
            end
        end
    end

    assign last_beat_c = (beat_q == BEAT_W'(N_BEATS - 1));

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            S_IDLE: begin
                if (recover_req) begin
                    state_d = S_RESTORE;
                    beat_d  = '0;
                end
            end
            S_RESTORE: begin
                if (last_beat_c) begin
                    state_d = S_IDLE;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            beat_q       <= '0;
            ready_q      <= 1'b1;
            free_valid_q <= '0;
            free_ptag_q  <= '0;
            for (int i = 0; i < ARCH_REGS; i++) begin
                map_q[i] <= PTAG_W'(i);
            end
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            ready_q      <= (state_d == S_IDLE);
            free_valid_q <= free_valid_d;
            free_ptag_q  <= free_ptag_d;
            map_q        <= map_d;
        end
    end

    // Restore stream is a decode of state/beat and the (frozen) map; zero when idle.
    always_comb begin
        restore_ptag = '0;
        for (int j = 0; j < RESTORE_LANES; j++) begin
            if (state_q == S_RESTORE) begin
                restore_ptag[j*PTAG_W +: PTAG_W] =
                    map_q[AREG_W'(32'(beat_q) * RESTORE_LANES + 32'(j))];
            end
        end
        for (int i = 0; i < ARCH_REGS; i++) begin
            rrf_map[i*PTAG_W +: PTAG_W] = map_q[i];
        end
    end

    assign commit_ready  = ready_q;
    assign free_valid    = free_valid_q;
    assign free_ptag     = free_ptag_q;
    assign restore_valid = (state_q == S_RESTORE);
    assign restore_base  = (state_q == S_RESTORE) ? AREG_W'(32'(beat_q) * RESTORE_LANES) : '0;
    assign restore_done  = (state_q == S_RESTORE) && last_beat_c;

`ifdef RRF_DUP_TAG_CHECK_EN
    logic                 dup_q;
    logic                 dup_hit_c;
    logic [ARCH_REGS-1:0] over_c;

    // Flag a committed tag that aliases a surviving map entry or another port's tag.
    always_comb begin
        over_c    = '0;
        dup_hit_c = 1'b0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (acc_c[k] && rd_c[k] != '0) begin
                over_c[rd_c[k]] = 1'b1;
            end
        end
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (acc_c[k] && rd_c[k] != '0) begin
                for (int r = 0; r < ARCH_REGS; r++) begin
                    if (AREG_W'(r) != rd_c[k] && !over_c[r] && map_q[r] == ptag_c[k]) begin
                        dup_hit_c = 1'b1;
                    end
                end
                for (int i = 0; i < k; i++) begin
                    if (acc_c[i] && rd_c[i] != '0 && rd_c[i] != rd_c[k] &&
                        ptag_c[i] == ptag_c[k]) begin
                        dup_hit_c = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dup_q <= 1'b0;
        end else begin
            dup_q <= dup_q | dup_hit_c;
        end
    end

    assign dup_err = dup_q;
`else
    assign dup_err = 1'b0;
`endif

endmodule

// File: tb/tb_rrf_multi_commit.sv
// Directed self-checking bench for rrf_multi_commit (default parameters).
module tb_rrf_multi_commit;

    localparam int unsigned ARCH_REGS = 32;
    localparam int unsigned PTAG_W    = 6;
    localparam int unsigned CW        = 2;
    localparam int unsigned LANES     = 8;
    localparam int unsigned AREG_W    = 5;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic [CW-1:0]               commit_valid;
    logic [CW*AREG_W-1:0]        commit_rd;
    logic [CW*PTAG_W-1:0]        commit_ptag;
    logic                        commit_ready;
    logic [CW-1:0]               free_valid;
    logic [CW*PTAG_W-1:0]        free_ptag;
    logic                        recover_req;
    logic                        restore_valid;
    logic [AREG_W-1:0]           restore_base;
    logic [LANES*PTAG_W-1:0]     restore_ptag;
    logic                        restore_done;
    logic [ARCH_REGS*PTAG_W-1:0] rrf_map;
    logic                        dup_err;

    int total = 0;
    int bad   = 0;
    logic [PTAG_W-1:0] exp_map [ARCH_REGS];

    rrf_multi_commit #(
        .ARCH_REGS(ARCH_REGS), .PTAG_W(PTAG_W),
        .COMMIT_WIDTH(CW), .RESTORE_LANES(LANES)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_ptag(commit_ptag),
        .commit_ready(commit_ready), .free_valid(free_valid), .free_ptag(free_ptag),
        .recover_req(recover_req), .restore_valid(restore_valid),
        .restore_base(restore_base), .restore_ptag(restore_ptag),
        .restore_done(restore_done), .rrf_map(rrf_map), .dup_err(dup_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [4:0] rd0, input logic [5:0] pt0,
                         input logic [4:0] rd1, input logic [5:0] pt1);
        commit_valid = v;
        commit_rd    = {rd1, rd0};
        commit_ptag  = {pt1, pt0};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; recover_req = 1'b0;
        drive(2'b00, 5'd0, 6'd0, 5'd0, 6'd0);
        #22 rst_n = 1'b1;
        tick();
        for (int i = 0; i < ARCH_REGS; i++) exp_map[i] = PTAG_W'(i);
        for (int i = 0; i < ARCH_REGS; i++) begin
            total++;
            if (rrf_map[i*PTAG_W +: PTAG_W] !== exp_map[i]) begin
                bad++; $display("FAIL reset_map[%0d] got=%0d exp=%0d", i, rrf_map[i*PTAG_W +: PTAG_W], exp_map[i]);
            end
        end
        total++; if (commit_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", commit_ready); end
        total++; if (free_valid !== 2'b00) begin bad++; $display("FAIL reset_free_valid got=%b exp=00", free_valid); end
        total++; if (restore_valid !== 1'b0) begin bad++; $display("FAIL reset_restore_valid got=%b exp=0", restore_valid); end
        total++; if (dup_err !== 1'b0) begin bad++; $display("FAIL reset_dup_err got=%b exp=0", dup_err); end
    endtask

    task automatic test_single();
        drive(2'b01, 5'd5, 6'd40, 5'd0, 6'd0);
        tick();
        drive(2'b00, 5'd0, 6'd0, 5'd0, 6'd0);
        exp_map[5] = 6'd40;
        total++; if (free_valid !== 2'b01) begin bad++; $display("FAIL single_free_valid got=%b exp=01", free_valid); end
        total++; if (free_ptag[5:0] !== 6'd5) begin bad++; $display("FAIL single_free_ptag got=%0d exp=5", free_ptag[5:0]); end
        total++; if (rrf_map[5*PTAG_W +: PTAG_W] !== 6'd40) begin bad++; $display("FAIL single_map5 got=%0d exp=40", rrf_map[5*PTAG_W +: PTAG_W]); end
        tick();
        total++; if (free_valid !== 2'b00) begin bad++; $display("FAIL single_free_one_cycle got=%b exp=00", free_valid); end
    endtask

    task automatic test_same_rd();
        drive(2'b11, 5'd3, 6'd33, 5'd3, 6'd34);
        tick();
        drive(2'b00, 5'd0, 6'd0, 5'd0, 6'd0);
        exp_map[3] = 6'd34;
        total++; if (rrf_map[3*PTAG_W +: PTAG_W] !== 6'd34) begin bad++; $display("FAIL samerd_map3 got=%0d exp=34", rrf_map[3*PTAG_W +: PTAG_W]); end
        total++; if (free_valid !== 2'b11) begin bad++; $display("FAIL samerd_free_valid got=%b exp=11", free_valid); end
        total++; if (free_ptag[5:0] !== 6'd3) begin bad++; $display("FAIL samerd_free0 got=%0d exp=3", free_ptag[5:0]); end
        total++; if (free_ptag[11:6] !== 6'd33) begin bad++; $display("FAIL samerd_free1 got=%0d exp=33", free_ptag[11:6]); end
    endtask

    task automatic test_rd_zero();
        drive(2'b11, 5'd0, 6'd50, 5'd5, 6'd41);
        tick();
        drive(2'b00, 5'd0, 6'd0, 5'd0, 6'd0);
        exp_map[5] = 6'd41;
        total++; if (rrf_map[5:0] !== 6'd0) begin bad++; $display("FAIL rd0_map0 got=%0d exp=0", rrf_map[5:0]); end
        total++; if (free_valid !== 2'b10) begin bad++; $display("FAIL rd0_free_valid got=%b exp=10", free_valid); end
        total++; if (free_ptag[11:6] !== 6'd40) begin bad++; $display("FAIL rd0_free1 got=%0d exp=40", free_ptag[11:6]); end
        total++; if (rrf_map[5*PTAG_W +: PTAG_W] !== 6'd41) begin bad++; $display("FAIL rd0_map5 got=%0d exp=41", rrf_map[5*PTAG_W +: PTAG_W]); end
    endtask

    task automatic test_recover();
        recover_req = 1'b1;
        drive(2'b01, 5'd7, 6'd45, 5'd0, 6'd0);
        tick();
        exp_map[7] = 6'd45;
        recover_req = 1'b0;
        // commit attempt while blocked must be dropped
        drive(2'b01, 5'd9, 6'd20, 5'd0, 6'd0);
        total++; if (free_valid !== 2'b01) begin bad++; $display("FAIL rec_free_valid got=%b exp=01", free_valid); end
        total++; if (free_ptag[5:0] !== 6'd7) begin bad++; $display("FAIL rec_free_ptag got=%0d exp=7", free_ptag[5:0]); end
        for (int b = 0; b < 4; b++) begin
            total++; if (restore_valid !== 1'b1) begin bad++; $display("FAIL rec_valid beat%0d got=%b exp=1", b, restore_valid); end
            total++; if (commit_ready !== 1'b0) begin bad++; $display("FAIL rec_ready beat%0d got=%b exp=0", b, commit_ready); end
            total++; if (restore_base !== 5'(b*8)) begin bad++; $display("FAIL rec_base beat%0d got=%0d exp=%0d", b, restore_base, b*8); end
            total++; if (restore_done !== (b == 3)) begin bad++; $display("FAIL rec_done beat%0d got=%b exp=%b", b, restore_done, (b == 3)); end
            for (int j = 0; j < LANES; j++) begin
                total++;
                if (restore_ptag[j*PTAG_W +: PTAG_W] !== exp_map[b*8+j]) begin
                    bad++; $display("FAIL rec_lane b%0d l%0d got=%0d exp=%0d", b, j, restore_ptag[j*PTAG_W +: PTAG_W], exp_map[b*8+j]);
                end
            end
            if (b == 0) begin
                total++; if (restore_ptag[47:42] !== 6'd45) begin bad++; $display("FAIL rec_lane7 got=%0d exp=45", restore_ptag[47:42]); end
            end
            if (b == 1) recover_req = 1'b1;
            tick();
            recover_req = 1'b0;
            if (b == 0) begin
                total++; if (free_valid !== 2'b00) begin bad++; $display("FAIL rec_blocked_free got=%b exp=00", free_valid); end
            end
        end
        drive(2'b00, 5'd0, 6'd0, 5'd0, 6'd0);
        total++; if (commit_ready !== 1'b1) begin bad++; $display("FAIL rec_after_ready got=%b exp=1", commit_ready); end
        total++; if (restore_valid !== 1'b0) begin bad++; $display("FAIL rec_after_valid got=%b exp=0", restore_valid); end
        total++; if (restore_ptag !== '0 || restore_base !== '0 || restore_done !== 1'b0) begin
            bad++; $display("FAIL rec_after_zero got base=%0d done=%b ptag=%h exp=0", restore_base, restore_done, restore_ptag);
        end
        total++; if (rrf_map[9*PTAG_W +: PTAG_W] !== 6'd9) begin bad++; $display("FAIL rec_blocked_map9 got=%0d exp=9", rrf_map[9*PTAG_W +: PTAG_W]); end
    endtask

    task automatic test_reset_mid_restore();
        recover_req = 1'b1;
        tick();
        recover_req = 1'b0;
        tick();
        tick();
        total++; if (restore_base !== 5'd16) begin bad++; $display("FAIL mid_base got=%0d exp=16", restore_base); end
        rst_n = 1'b0;
        #1;
        total++; if (restore_valid !== 1'b0 || restore_base !== '0 || restore_ptag !== '0 || restore_done !== 1'b0) begin
            bad++; $display("FAIL mid_reset_zero got v=%b base=%0d done=%b exp=0", restore_valid, restore_base, restore_done);
        end
        total++; if (commit_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_ready got=%b exp=1", commit_ready); end
        total++; if (rrf_map[5*PTAG_W +: PTAG_W] !== 6'd5 || rrf_map[7*PTAG_W +: PTAG_W] !== 6'd7) begin
            bad++; $display("FAIL mid_reset_map got5=%0d got7=%0d exp=5,7", rrf_map[5*PTAG_W +: PTAG_W], rrf_map[7*PTAG_W +: PTAG_W]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < ARCH_REGS; i++) exp_map[i] = PTAG_W'(i);
        tick();
        total++; if (restore_valid !== 1'b0) begin bad++; $display("FAIL mid_after_valid got=%b exp=0", restore_valid); end
    endtask

    task automatic test_dup();
        drive(2'b01, 5'd4, 6'd9, 5'd0, 6'd0);
        tick();
        drive(2'b00, 5'd0, 6'd0, 5'd0, 6'd0);
`ifdef RRF_DUP_TAG_CHECK_EN
        total++; if (dup_err !== 1'b1) begin bad++; $display("FAIL dup_set got=%b exp=1", dup_err); end
        tick();
        total++; if (dup_err !== 1'b1) begin bad++; $display("FAIL dup_sticky got=%b exp=1", dup_err); end
`else
        total++; if (dup_err !== 1'b0) begin bad++; $display("FAIL dup_off got=%b exp=0", dup_err); end
        tick();
        total++; if (dup_err !== 1'b0) begin bad++; $display("FAIL dup_off_hold got=%b exp=0", dup_err); end
`endif
        total++; if (rrf_map[4*PTAG_W +: PTAG_W] !== 6'd9) begin bad++; $display("FAIL dup_map4 got=%0d exp=9", rrf_map[4*PTAG_W +: PTAG_W]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_same_rd();
        test_rd_zero();
        test_recover();
        test_reset_mid_restore();
        test_dup();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
